counter_uart_reporter: RTL and testbench
========================================

COUNTER_UART_REPORTER -- requirements
Module: counter_uart_reporter

Interface
REQ-001 The block SHALL have parameter SEND_CRLF, default 1, meaning append CR LF (0x0D 0x0A) after the digits when 1.
REQ-002 The block SHALL have parameter MAX_VALUE, default 9999, meaning the largest value reported numerically.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  asynchronous active-low reset; 0 resets all state immediately.
REQ-006 Port: i_counter  input  14  counter value to report, binary.
REQ-007 Port: i_report  input  1  single-cycle report request.
REQ-008 Port: i_auto  input  1  level; 1 = report automatically whenever i_counter differs from the last reported value.
REQ-009 Port: i_tx_full  input  1  downstream TX FIFO full.
REQ-010 Port: o_tx_push  output  1  FIFO write strobe, one byte per high cycle.
REQ-011 Port: o_tx_data  output  8  ASCII byte, valid when o_tx_push=1.
REQ-012 Port: o_busy  output  1  frame in progress.
REQ-013 Port: o_drop  output  1  one-cycle pulse when i_report is ignored.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SEND; reset state IDLE.
REQ-015 Trigger in IDLE SHALL be i_report=1, or i_auto=1 with i_counter != last_value; both together SHALL start exactly one frame.
REQ-016 On trigger in cycle N the block SHALL capture i_counter into a snapshot register and enter LOAD at N+1.
REQ-017 LOAD SHALL last exactly one cycle, convert the snapshot into four BCD digits (thousands first), and go to SEND.
REQ-018 Frame SHALL be four ASCII digits 0x30+digit, leading zeros kept, then 0x0D 0x0A when SEND_CRLF=1: 6 bytes, otherwise 4.
REQ-019 A snapshot above MAX_VALUE SHALL be sent as four 0x2D ('-') bytes in place of the digits.
REQ-020 In SEND, o_tx_push SHALL be 1 exactly in the cycles where i_tx_full=0, combinationally gated by i_tx_full.
REQ-021 The byte index SHALL advance only on a cycle with o_tx_push=1.
REQ-022 While i_tx_full=1, o_tx_data SHALL hold the current byte; no byte SHALL be lost or duplicated.
REQ-023 The earliest first push SHALL be at N+2; with i_tx_full=0 throughout, pushes SHALL occur on consecutive cycles.
REQ-024 The cycle after the last push the FSM SHALL return to IDLE and load last_value with the snapshot.
REQ-025 o_busy SHALL be 1 in LOAD and SEND and 0 in IDLE.
REQ-026 i_report=1 while not in IDLE SHALL be ignored and SHALL pulse o_drop for that one cycle.
REQ-027 Changes of i_counter during a frame SHALL NOT alter the frame in progress.
REQ-028 Auto changes during a frame SHALL coalesce: back in IDLE, at most one new frame starts, carrying the i_counter value at that cycle.
REQ-029 A new trigger SHALL be accepted on the first IDLE cycle after a frame, giving at least one idle cycle between frames.

Reset
REQ-030 On rst=0, the block SHALL force state IDLE, o_tx_push=0, o_tx_data=0x00, o_busy=0, o_drop=0, snapshot=0, last_value=0, byte index=0, regardless of clk.
REQ-031 On reset mid-frame the block SHALL abandon the frame; after release no residual byte SHALL be pushed unless a new trigger occurs.

Verification
REQ-032 The bench SHALL check: i_counter=1234, i_report pulse at N, i_tx_full=0 -> pushes 0x31,0x32,0x33,0x34,0x0D,0x0A at N+2..N+7, o_busy=0 at N+8.
REQ-033 The bench SHALL check: i_counter=7 with SEND_CRLF=0 -> exactly 4 pushes 0x30,0x30,0x30,0x37, with no CR LF.
REQ-034 The bench SHALL check: i_counter=5678, i_tx_full high for 3 cycles right after the 2nd push -> no push in those cycles, o_tx_data holds 0x37, then 0x37,0x38,0x0D,0x0A, 6 bytes total.
REQ-035 The bench SHALL check: i_report pulse while o_busy=1 -> o_drop high for 1 cycle and only one frame is emitted.
REQ-036 The bench SHALL check: i_auto=1, i_counter 0->1 -> frame "0001"; i_counter stepping to 2 then 3 during that frame -> exactly one further frame "0003"; i_counter=12000 with i_report -> 0x2D x4 then CR LF.
REQ-037 The bench SHALL check: rst=0 asserted after the 3rd push -> o_tx_push and o_busy drop to 0 asynchronously, and no push occurs after release without a new trigger.

Source files
------------

// File: rtl/counter_uart_reporter_if.sv
// TX FIFO write port shared between the reporter (master) and the
// downstream byte FIFO (slave). The master pushes one ASCII byte per
// high cycle of o_tx_push; the slave back-pressures with i_tx_full.
interface counter_uart_reporter_if;
   logic       o_tx_push;
   logic [7:0] o_tx_data;
   logic       i_tx_full;

   modport master (
      output o_tx_push,
      output o_tx_data,
      input  i_tx_full
   );

   modport slave (
      input  o_tx_push,
      input  o_tx_data,
      output i_tx_full
   );
endinterface

// File: rtl/counter_uart_reporter.sv
// Counter reporter: snapshots a 14-bit counter on request (or automatically
// when it changes), converts it to four decimal ASCII digits and streams the
// frame into a TX FIFO, optionally terminated by CR LF. Values above
// MAX_VALUE are reported as "----". Requests arriving while a frame is in
// flight are dropped and flagged; automatic changes coalesce into one frame.
module counter_uart_reporter #(
   parameter int SEND_CRLF = 1,
   parameter int MAX_VALUE = 9999
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [13:0]                     i_counter,
   input  logic                            i_report,
   input  logic                            i_auto,
   counter_uart_reporter_if.master         tx,
   output logic                            o_busy,
   output logic                            o_drop
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   // Four digits can only show up to 9999, so a larger limit is clamped.
   localparam int          MAX_CLAMP = (MAX_VALUE > 9999) ? 9999 :
                                       ((MAX_VALUE < 0) ? 0 : MAX_VALUE);
   localparam logic [13:0] MAX_L     = 14'(MAX_CLAMP);
   // Index of the final byte of a frame: digits 0..3, then CR (4), LF (5).
   localparam logic [2:0]  LAST_IDX  = (SEND_CRLF != 0) ? 3'd5 : 3'd3;

   state_t      state_q, state_d;
   logic [13:0] snap_q, snap_d;
   logic [13:0] last_q, last_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] digits_q, digits_d;
   logic        ovf_q, ovf_d;

   logic [19:0] bcd_w;
   logic        trigger_w;
   logic        push_w;
   logic [7:0]  cur_byte_w;
   logic [3:0]  cur_digit_w;

   // Shift-and-add-3 binary to BCD; five digits cover the full 14-bit range
   // so that the ten-thousands digit can flag out-of-range values.
   function automatic logic [19:0] bin_to_bcd(input logic [13:0] bin);
      logic [19:0] bcd;
      bcd = '0;
      for (int b = 13; b >= 0; b--) begin
         for (int d = 0; d < 5; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
               bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
         end
         bcd = {bcd[18:0], bin[b]};
      end
      return bcd;
   endfunction

   // Conversion of the frozen snapshot; only consumed during LOAD.
   always_comb begin
      bcd_w = bin_to_bcd(snap_q);
   end

   // Digit under the byte index, thousands first.
   always_comb begin
      cur_digit_w = 4'd0;
      case (idx_q)
         3'd0:    cur_digit_w = digits_q[15:12];
         3'd1:    cur_digit_w = digits_q[11:8];
         3'd2:    cur_digit_w = digits_q[7:4];
         3'd3:    cur_digit_w = digits_q[3:0];
         default: cur_digit_w = 4'd0;
      endcase
   end

   // ASCII byte for the current index; held steady while the FIFO is full.
   always_comb begin
      cur_byte_w = 8'h00;
      if (idx_q <= 3'd3) begin
         cur_byte_w = ovf_q ? 8'h2D : {4'h3, cur_digit_w};
      end else if (idx_q == 3'd4) begin
         cur_byte_w = 8'h0D;
      end else if (idx_q == 3'd5) begin
         cur_byte_w = 8'h0A;
      end
   end

   // Next-state and output logic of the frame sequencer.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      last_d    = last_q;
      idx_d     = idx_q;
      digits_d  = digits_q;
      ovf_d     = ovf_q;
      trigger_w = i_report || (i_auto && (i_counter != last_q));
      push_w    = 1'b0;

      case (state_q)
         IDLE: begin
            idx_d = 3'd0;
            if (trigger_w) begin
               snap_d  = i_counter;
               state_d = LOAD;
            end
         end
         LOAD: begin
            digits_d = bcd_w[15:0];
            ovf_d    = (snap_q > MAX_L) || (bcd_w[19:16] != 4'd0);
            idx_d    = 3'd0;
            state_d  = SEND;
         end
         SEND: begin
            push_w = !tx.i_tx_full;
            if (push_w) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 3'd0;
                  last_d  = snap_q;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   // Push is gated combinationally by i_tx_full; outputs collapse to their
   // idle values as soon as the asynchronous reset forces the state to IDLE.
   assign tx.o_tx_push = push_w;
   assign tx.o_tx_data = (state_q == SEND) ? cur_byte_w : 8'h00;
   assign o_busy       = (state_q != IDLE);
   assign o_drop       = i_report && (state_q != IDLE);

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         snap_q   <= '0;
         last_q   <= '0;
         idx_q    <= '0;
         digits_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         snap_q   <= snap_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         digits_q <= digits_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Directed bench for counter_uart_reporter. A reference model turns each
// expected frame value into its byte sequence with decimal arithmetic; a
// compare process matches every push of both DUT instances against those
// byte queues, while the directed sequences pin exact cycles and literals.
module tb_counter_uart_reporter;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] counter, counter4;
   logic        report, report4, auto_m, auto4;
   logic        busy, drop, busy4, drop4;

   always #5 clk = ~clk;

   counter_uart_reporter_if tf ();
   counter_uart_reporter_if tf4 ();

   counter_uart_reporter dut (
      .clk       (clk),
      .rst       (rst),
      .i_counter (counter),
      .i_report  (report),
      .i_auto    (auto_m),
      .tx        (tf),
      .o_busy    (busy),
      .o_drop    (drop)
   );

   counter_uart_reporter #(.SEND_CRLF(0)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .i_counter (counter4),
      .i_report  (report4),
      .i_auto    (auto4),
      .tx        (tf4),
      .o_busy    (busy4),
      .o_drop    (drop4)
   );

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp4_q[$];
   logic [7:0] got_q[$];

   logic [7:0] lit1 [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
   logic [7:0] lit2 [4] = '{8'h30, 8'h30, 8'h30, 8'h37};
   logic [7:0] lit3 [9] = '{8'h35, 8'h36, 8'h37, 8'h37, 8'h37, 8'h37, 8'h38, 8'h0D, 8'h0A};
   logic [7:0] lit5 [6] = '{8'h2D, 8'h2D, 8'h2D, 8'h2D, 8'h0D, 8'h0A};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Expected frame for a value: four decimal digits or dashes, then CR LF.
   task automatic add_frame(input int v, input bit crlf, input bit four);
      logic [7:0] b[$];
      int p;
      int d;
      p = 1000;
      for (int k = 0; k < 4; k++) begin
         if (v > 9999) begin
            b.push_back(8'h2D);
         end else begin
            d = (v / p) % 10;
            b.push_back(8'h30 + 8'(d));
         end
         p = p / 10;
      end
      if (crlf) begin
         b.push_back(8'h0D);
         b.push_back(8'h0A);
      end
      foreach (b[i]) begin
         if (four) exp4_q.push_back(b[i]);
         else      exp_q.push_back(b[i]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic negs();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      chk(name, 32'(busy), 32'd0);
   endtask

   // Stream compare: every push must match the model's next byte.
   always @(negedge clk) begin
      if (rst) begin
         if (tf.o_tx_push) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_push actual=%02h required=none", tf.o_tx_data);
            end else begin
               chk("stream_byte", 32'(tf.o_tx_data), 32'(exp_q.pop_front()));
            end
         end
         if (tf.i_tx_full) chk("push_gated_by_full", 32'(tf.o_tx_push), 32'd0);
         if (tf4.o_tx_push) begin
            if (exp4_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_push4 actual=%02h required=none", tf4.o_tx_data);
            end else begin
               chk("stream4_byte", 32'(tf4.o_tx_data), 32'(exp4_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int cnt;
      rst = 1'b0;
      counter = '0; counter4 = '0;
      report = 1'b0; report4 = 1'b0; auto_m = 1'b0; auto4 = 1'b0;
      tf.i_tx_full = 1'b0; tf4.i_tx_full = 1'b0;
      #12;
      chk("rst_push", 32'(tf.o_tx_push), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_drop", 32'(drop), 32'd0);
      chk("rst_data", 32'(tf.o_tx_data), 32'd0);
      negs();
      rst = 1'b1;
      tick(); tick();

      // 1234 with CR LF, no back-pressure: pushes at N+2..N+7
      add_frame(1234, 1'b1, 1'b0);
      counter = 14'd1234; report = 1'b1;
      negs();
      chk("t1_n_push", 32'(tf.o_tx_push), 32'd0);
      chk("t1_n_drop", 32'(drop), 32'd0);
      tick(); report = 1'b0;
      negs();
      chk("t1_load_busy", 32'(busy), 32'd1);
      chk("t1_load_push", 32'(tf.o_tx_push), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick(); negs();
         chk("t1_push", 32'(tf.o_tx_push), 32'd1);
         chk("t1_byte", 32'(tf.o_tx_data), 32'(lit1[i]));
      end
      tick(); negs();
      chk("t1_busy_n8", 32'(busy), 32'd0);
      chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // 7 without CR LF: exactly four bytes
      add_frame(7, 1'b0, 1'b1);
      counter4 = 14'd7; report4 = 1'b1;
      tick(); report4 = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         negs();
         if (tf4.o_tx_push) begin
            if (cnt < 4) chk("t2_byte", 32'(tf4.o_tx_data), 32'(lit2[cnt]));
            cnt++;
         end
         tick();
      end
      chk("t2_count", 32'(cnt), 32'd4);
      chk("t2_queue_empty", 32'(exp4_q.size()), 32'd0);

      // 5678 with FIFO full for three cycles after the second push
      add_frame(5678, 1'b1, 1'b0);
      counter = 14'd5678; report = 1'b1;
      tick(); report = 1'b0;
      cnt = 0;
      for (int j = 0; j < 9; j++) begin
         tick();
         tf.i_tx_full = (j >= 2 && j <= 4);
         negs();
         chk("t3_push", 32'(tf.o_tx_push), (j >= 2 && j <= 4) ? 32'd0 : 32'd1);
         chk("t3_data", 32'(tf.o_tx_data), 32'(lit3[j]));
         if (tf.o_tx_push) cnt++;
      end
      tick(); tf.i_tx_full = 1'b0;
      negs();
      chk("t3_busy_end", 32'(busy), 32'd0);
      chk("t3_count", 32'(cnt), 32'd6);
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // report while busy is dropped with a one-cycle pulse
      add_frame(42, 1'b1, 1'b0);
      counter = 14'd42; report = 1'b1;
      tick(); report = 1'b0;
      tick(); tick();
      report = 1'b1;
      negs();
      chk("t4_drop_pulse", 32'(drop), 32'd1);
      tick(); report = 1'b0;
      negs();
      chk("t4_drop_clear", 32'(drop), 32'd0);
      wait_idle("t4_wait_idle", 20);
      for (int i = 0; i < 5; i++) begin
         tick(); negs();
         chk("t4_single_frame", 32'(busy), 32'd0);
      end
      chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

      // auto mode from reset state, coalescing, and out-of-range value
      negs(); rst = 1'b0;
      counter = 14'd0; auto_m = 1'b1;
      tick(); tick(); rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); negs();
         chk("t5_no_auto_at_last", 32'(busy), 32'd0);
      end
      tick();
      counter = 14'd1;
      add_frame(1, 1'b1, 1'b0);
      tick(); tick();
      tick(); counter = 14'd2;
      tick(); counter = 14'd3;
      tick(); tick(); tick();
      negs();
      chk("t5_last_push", 32'(tf.o_tx_push), 32'd1);
      tick();
      add_frame(3, 1'b1, 1'b0);
      negs();
      chk("t5_idle_gap", 32'(busy), 32'd0);
      tick(); negs();
      chk("t5_second_frame", 32'(busy), 32'd1);
      wait_idle("t5_wait_idle", 20);
      for (int i = 0; i < 3; i++) begin
         tick(); negs();
         chk("t5_no_third_frame", 32'(busy), 32'd0);
      end
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      auto_m = 1'b0;
      add_frame(12000, 1'b1, 1'b0);
      counter = 14'd12000; report = 1'b1;
      tick(); report = 1'b0;
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         negs();
         if (tf.o_tx_push) got_q.push_back(tf.o_tx_data);
         tick();
      end
      chk("t5_dash_count", 32'(got_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < got_q.size()) chk("t5_dash_byte", 32'(got_q[i]), 32'(lit5[i]));
      end
      chk("t5_dash_queue_empty", 32'(exp_q.size()), 32'd0);

      // reset mid-frame after the third push
      add_frame(1234, 1'b1, 1'b0);
      counter = 14'd1234; report = 1'b1;
      tick(); report = 1'b0;
      tick(); tick(); tick();
      negs();
      chk("t6_third_push", 32'(tf.o_tx_data), 32'h33);
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_push", 32'(tf.o_tx_push), 32'd0);
      chk("t6_async_busy", 32'(busy), 32'd0);
      chk("t6_async_data", 32'(tf.o_tx_data), 32'd0);
      exp_q.delete();
      tick(); tick();
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         negs();
         if (tf.o_tx_push) cnt++;
         tick();
      end
      chk("t6_no_residual", 32'(cnt), 32'd0);
      chk("t6_idle_after", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
